// File: rtl/ref_mem_pkg.sv
// Shared constants and types for the reference search-window buffer.
package ref_mem_pkg;

  localparam int unsigned NUM_BANK = 32;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DEPTH    = 128;

  // Output mode encodings on rdR_sel; any other value behaves as full row.
  localparam logic [3:0] RDSEL_FULL = 4'd0;
  localparam logic [3:0] RDSEL_DEC2 = 4'd1;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] bank_addr_t;

endpackage

// File: rtl/ref_bank_ram.sv
// Single one-pixel-wide bank: one write port, one registered read-first read port.
module ref_bank_ram
  import ref_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  bank_addr_t wr_addr,
  input  pix_t       wr_data,
  input  logic       re,
  input  bank_addr_t rd_addr,
  output pix_t       rd_data
);

  pix_t mem [DEPTH];
  pix_t rd_data_d;
  pix_t rd_data_q;

  // Next read value: new word when enabled, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; sampled on the same edge as a write, so it sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ref_mem_bank_array.sv
// 32-bank reference buffer: per-bank read/write, then rotate and optionally decimate.
module ref_mem_bank_array
  import ref_mem_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANK-1:0]          Bank_sel,
  input  logic [NUM_BANK*ADDR_W-1:0]   write_address_all,
  input  logic [NUM_BANK*PIX_W-1:0]    wr_data,
  input  logic [NUM_BANK*ADDR_W-1:0]   rd_address_all,
  input  logic                         rd8R_en,
  input  logic [3:0]                   rdR_sel,
  input  logic [4:0]                   shift_value,
  output logic [NUM_BANK*PIX_W-1:0]    ref_row,
  output logic                         ref_valid
);

  logic rd_en;
  pix_t raw [NUM_BANK];

  assign rd_en = ~rd8R_en;

  for (genvar k = 0; k < NUM_BANK; k++) begin : g_bank
    ref_bank_ram u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (Bank_sel[k]),
      .wr_addr (write_address_all[ADDR_W*k +: ADDR_W]),
      .wr_data (wr_data[PIX_W*k +: PIX_W]),
      .re      (rd_en),
      .rd_addr (rd_address_all[ADDR_W*k +: ADDR_W]),
      .rd_data (raw[k])
    );
  end

  logic [4:0]                shift_d, shift_q;
  logic [3:0]                mode_d, mode_q;
  logic                      v1_d, v1_q;
  logic [NUM_BANK*PIX_W-1:0] ref_row_d, ref_row_q;
  logic                      ref_valid_d, ref_valid_q;
  pix_t                      rot [NUM_BANK];

  // Stage 1 side-band: capture shift/mode with the bank reads, hold otherwise.
  always_comb begin
    shift_d = shift_q;
    mode_d  = mode_q;
    v1_d    = rd_en;
    if (rd_en) begin
      shift_d = shift_value;
      mode_d  = rdR_sel;
    end
  end

  // Stage 2: rotate by the captured shift (5-bit wrap), then select full or 2:1 row.
  always_comb begin
    for (int unsigned j = 0; j < NUM_BANK; j++) begin
      rot[j] = raw[5'(j + 32'(shift_q))];
    end
    ref_row_d   = ref_row_q;
    ref_valid_d = v1_q;
    if (v1_q) begin
      for (int unsigned j = 0; j < NUM_BANK; j++) begin
        case (mode_q)
          RDSEL_DEC2: ref_row_d[PIX_W*j +: PIX_W] = rot[5'(2 * (j % 16))];
          default:    ref_row_d[PIX_W*j +: PIX_W] = rot[j];
        endcase
      end
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      mode_q      <= '0;
      v1_q        <= 1'b0;
      ref_row_q   <= '0;
      ref_valid_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      v1_q        <= v1_d;
      ref_row_q   <= ref_row_d;
      ref_valid_q <= ref_valid_d;
    end
  end

  assign ref_row   = ref_row_q;
  assign ref_valid = ref_valid_q;

endmodule

// File: tb/tb_ref_mem_bank_array.sv
// Directed self-checking bench for ref_mem_bank_array.
module tb_ref_mem_bank_array;
  import ref_mem_pkg::*;

  localparam int RW = NUM_BANK * PIX_W;
  localparam int AW = NUM_BANK * ADDR_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_BANK-1:0] Bank_sel;
  logic [AW-1:0]       write_address_all;
  logic [RW-1:0]       wr_data;
  logic [AW-1:0]       rd_address_all;
  logic                rd8R_en;
  logic [3:0]          rdR_sel;
  logic [4:0]          shift_value;
  logic [RW-1:0]       ref_row;
  logic                ref_valid;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ref_mem_bank_array dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .wr_data           (wr_data),
    .rd_address_all    (rd_address_all),
    .rd8R_en           (rd8R_en),
    .rdR_sel           (rdR_sel),
    .shift_value       (shift_value),
    .ref_row           (ref_row),
    .ref_valid         (ref_valid)
  );

  function automatic logic [AW-1:0] bcast_addr(input logic [ADDR_W-1:0] a);
    logic [AW-1:0] v;
    for (int k = 0; k < NUM_BANK; k++) v[ADDR_W*k +: ADDR_W] = a;
    return v;
  endfunction

  // One write cycle: drive at negedge, written at the following posedge.
  task automatic wr(input logic [NUM_BANK-1:0] sel, input logic [ADDR_W-1:0] a,
                    input logic [RW-1:0] d);
    Bank_sel          = sel;
    write_address_all = bcast_addr(a);
    wr_data           = d;
    @(negedge clk);
    Bank_sel = '0;
  endtask

  // One read; returns at the negedge where the resulting row is on ref_row.
  task automatic rd(input logic [AW-1:0] av, input logic [4:0] sh, input logic [3:0] md);
    rd_address_all = av;
    shift_value    = sh;
    rdR_sel        = md;
    rd8R_en        = 1'b0;
    @(negedge clk);
    rd8R_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if (ref_row !== '0) $display("FAIL reset_row: got %h expected 0", ref_row);
    else passed++;
    checks++;
    if (ref_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ref_valid);
    else passed++;
  endtask

  task automatic test_fill;
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    d = '0;
    for (int k = 0; k < NUM_BANK; k++) d[PIX_W*k +: PIX_W] = 8'hEE;
    wr('1, 7'd5, d);
    for (int a = 0; a < 96; a++) begin
      d = '0;
      for (int k = 0; k < 4; k++) d[PIX_W*k +: PIX_W] = 8'(k + a);
      wr(32'h0000_000F, 7'(a), d);
    end
    for (int k = 0; k < NUM_BANK; k++) e[PIX_W*k +: PIX_W] = (k < 4) ? 8'(k + 5) : 8'hEE;
    rd(bcast_addr(7'd5), 5'd0, 4'd0);
    checks++;
    if (ref_valid !== 1'b1) $display("FAIL fill_valid: got %b expected 1", ref_valid);
    else passed++;
    checks++;
    if (ref_row !== e) $display("FAIL fill_row: got %h expected %h", ref_row, e);
    else passed++;
  endtask

  task automatic test_rotation;
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    for (int k = 0; k < NUM_BANK; k++) d[PIX_W*k +: PIX_W] = 8'(k);
    wr('1, 7'd10, d);
    for (int j = 0; j < NUM_BANK; j++) e[PIX_W*j +: PIX_W] = 8'((j + 8) % 32);
    rd(bcast_addr(7'd10), 5'd8, 4'd0);
    checks++;
    if (ref_row !== e) $display("FAIL rot_row: got %h expected %h", ref_row, e);
    else passed++;
    checks++;
    if (ref_row[PIX_W*24 +: PIX_W] !== 8'd0 || ref_row[PIX_W*31 +: PIX_W] !== 8'd7)
      $display("FAIL rot_wrap: got p24=%0d p31=%0d expected 0 7",
               ref_row[PIX_W*24 +: PIX_W], ref_row[PIX_W*31 +: PIX_W]);
    else passed++;
  endtask

  task automatic test_decimation;
    logic [RW-1:0] e;
    for (int j = 0; j < NUM_BANK; j++) e[PIX_W*j +: PIX_W] = 8'(2 * (j % 16));
    rd(bcast_addr(7'd10), 5'd0, 4'd1);
    checks++;
    if (ref_row !== e) $display("FAIL dec2_row: got %h expected %h", ref_row, e);
    else passed++;
    for (int j = 0; j < NUM_BANK; j++) e[PIX_W*j +: PIX_W] = 8'(j);
    rd(bcast_addr(7'd10), 5'd0, 4'd7);
    checks++;
    if (ref_row !== e) $display("FAIL mode7_row: got %h expected %h", ref_row, e);
    else passed++;
  endtask

  task automatic test_split_addr;
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    logic [AW-1:0] av;
    for (int k = 0; k < NUM_BANK; k++) d[PIX_W*k +: PIX_W] = 8'(8'h40 + k);
    wr('1, 7'd3, d);
    for (int k = 0; k < NUM_BANK; k++) d[PIX_W*k +: PIX_W] = 8'(8'h80 + k);
    wr('1, 7'd27, d);
    for (int k = 0; k < NUM_BANK; k++) av[ADDR_W*k +: ADDR_W] = (k < 24) ? 7'd3 : 7'd27;
    for (int j = 0; j < NUM_BANK; j++) begin
      int s;
      s = (j + 8) % 32;
      e[PIX_W*j +: PIX_W] = (s < 24) ? 8'(8'h40 + s) : 8'(8'h80 + s);
    end
    rd(av, 5'd8, 4'd0);
    checks++;
    if (ref_row !== e) $display("FAIL split_row: got %h expected %h", ref_row, e);
    else passed++;
  endtask

  // Read-first collision followed by a back-to-back re-read, then held output.
  task automatic test_back_to_back;
    logic [RW-1:0] d;
    d = '0;
    d[PIX_W*2 +: PIX_W] = 8'h11;
    wr(32'h4, 7'd4, d);
    d[PIX_W*2 +: PIX_W] = 8'hAA;
    Bank_sel          = 32'h4;
    write_address_all = bcast_addr(7'd4);
    wr_data           = d;
    rd_address_all    = bcast_addr(7'd4);
    shift_value       = 5'd0;
    rdR_sel           = 4'd0;
    rd8R_en           = 1'b0;
    @(negedge clk);
    Bank_sel = '0;
    @(negedge clk);
    rd8R_en = 1'b1;
    checks++;
    if (ref_valid !== 1'b1 || ref_row[PIX_W*2 +: PIX_W] !== 8'h11)
      $display("FAIL collide_old: got v=%b p2=%h expected v=1 p2=11",
               ref_valid, ref_row[PIX_W*2 +: PIX_W]);
    else passed++;
    @(negedge clk);
    checks++;
    if (ref_valid !== 1'b1 || ref_row[PIX_W*2 +: PIX_W] !== 8'hAA)
      $display("FAIL collide_new: got v=%b p2=%h expected v=1 p2=aa",
               ref_valid, ref_row[PIX_W*2 +: PIX_W]);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ref_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0 (cycle %0d)", ref_valid, c);
      else passed++;
      checks++;
      if (ref_row[PIX_W*2 +: PIX_W] !== 8'hAA)
        $display("FAIL idle_hold: got %h expected aa (cycle %0d)", ref_row[PIX_W*2 +: PIX_W], c);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    logic [RW-1:0] e;
    rd_address_all = bcast_addr(7'd10);
    shift_value    = 5'd0;
    rdR_sel        = 4'd0;
    rd8R_en        = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (ref_valid !== 1'b1) $display("FAIL prereset_valid: got %b expected 1", ref_valid);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ref_row !== '0) $display("FAIL midreset_row: got %h expected 0", ref_row);
    else passed++;
    checks++;
    if (ref_valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", ref_valid);
    else passed++;
    @(negedge clk);
    rd8R_en = 1'b1;
    rst_n   = 1'b1;
    @(negedge clk);
    checks++;
    if (ref_valid !== 1'b0) $display("FAIL postreset_valid: got %b expected 0", ref_valid);
    else passed++;
    for (int j = 0; j < NUM_BANK; j++) e[PIX_W*j +: PIX_W] = 8'(j);
    rd(bcast_addr(7'd10), 5'd0, 4'd0);
    checks++;
    if (ref_valid !== 1'b1 || ref_row !== e)
      $display("FAIL reread_row: got v=%b %h expected v=1 %h", ref_valid, ref_row, e);
    else passed++;
  endtask

  initial begin
    rst_n             = 1'b0;
    Bank_sel          = '0;
    write_address_all = '0;
    wr_data           = '0;
    rd_address_all    = '0;
    rd8R_en           = 1'b1;
    rdR_sel           = 4'd0;
    shift_value       = 5'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_fill();
    test_rotation();
    test_decimation();
    test_split_addr();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
